// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - request handshake and datapath strobe bundle for alu_sequencer
interface alu_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [4:0] op;
    logic       b_zero;
    logic [4:0] ALU_ctrl;
    logic       Yin;
    logic       Zin;
    logic       Zlowout;
    logic       Zhighout;
    logic       Rin;
    logic       LOin;
    logic       HIin;
    logic       busy;
    logic       done;
    logic       err;

    modport slave (
        input  req_valid, op, b_zero,
        output req_ready, ALU_ctrl, Yin, Zin, Zlowout, Zhighout,
               Rin, LOin, HIin, busy, done, err
    );

    modport master (
        output req_valid, op, b_zero,
        input  req_ready, ALU_ctrl, Yin, Zin, Zlowout, Zhighout,
               Rin, LOin, HIin, busy, done, err
    );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle ALU operation sequencer driving datapath strobes
module alu_sequencer #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic           clk,
    input  logic           clr,
    alu_sequencer_if.slave bus
);
    localparam logic [4:0] OP_MUL = 5'd2;
    localparam logic [4:0] OP_DIV = 5'd3;
    localparam logic [4:0] OP_MAX = 5'd11;

    typedef enum logic [2:0] {
        IDLE, LOAD_Y, EXEC, WAIT, WB_LO, WB_HI, DONE
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic [4:0] op_q;
    logic [7:0] phase_len;
    logic       is_md;
    logic       div_zero;

    always_comb begin
        phase_len = 8'd1;
        if (op_q == OP_MUL)
            phase_len = 8'(MUL_CYCLES);
        else if (op_q == OP_DIV)
            phase_len = 8'(DIV_CYCLES);
    end

    assign is_md         = (op_q == OP_MUL) || (op_q == OP_DIV);
    assign div_zero      = (op_q == OP_DIV) && bus.b_zero;
    assign bus.req_ready = (state == IDLE) && !clr;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            op_q         <= 5'd0;
            bus.ALU_ctrl <= 5'd0;
            bus.Yin      <= 1'b0;
            bus.Zin      <= 1'b0;
            bus.Zlowout  <= 1'b0;
            bus.Zhighout <= 1'b0;
            bus.Rin      <= 1'b0;
            bus.LOin     <= 1'b0;
            bus.HIin     <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q     <= bus.op;
                        bus.busy <= 1'b1;
                        if (bus.op > OP_MAX) begin
                            bus.err  <= 1'b1;
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            bus.err <= 1'b0;
                            bus.Yin <= 1'b1;
                            state   <= LOAD_Y;
                        end
                    end
                end
                LOAD_Y: begin
                    bus.Yin      <= 1'b0;
                    bus.ALU_ctrl <= op_q;
                    cnt          <= phase_len - 8'd1;
                    // A one-cycle phase makes EXEC itself the final compute cycle.
                    bus.Zin      <= (phase_len == 8'd1) && !div_zero;
                    state        <= EXEC;
                end
                EXEC, WAIT: begin
                    if (state == EXEC && div_zero) begin
                        bus.err  <= 1'b1;
                        bus.Zin  <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else if (cnt == 8'd0) begin
                        bus.Zin     <= 1'b0;
                        bus.Zlowout <= 1'b1;
                        bus.LOin    <= is_md;
                        bus.Rin     <= !is_md;
                        state       <= WB_LO;
                    end else begin
                        cnt     <= cnt - 8'd1;
                        bus.Zin <= (cnt == 8'd1);
                        state   <= WAIT;
                    end
                end
                WB_LO: begin
                    bus.Zlowout <= 1'b0;
                    bus.LOin    <= 1'b0;
                    bus.Rin     <= 1'b0;
                    if (is_md) begin
                        bus.Zhighout <= 1'b1;
                        bus.HIin     <= 1'b1;
                        state        <= WB_HI;
                    end else begin
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                WB_HI: begin
                    bus.Zhighout <= 1'b0;
                    bus.HIin     <= 1'b0;
                    bus.done     <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - randomized self-checking bench for alu_sequencer
module tb_alu_sequencer;
    localparam int MUL_N = 4;
    localparam int DIV_N = 8;

    logic clk = 1'b0;
    logic clr;
    int   checks = 0;
    int   fails  = 0;
    int   last_alu = 0;

    always #5 clk = ~clk;

    alu_sequencer_if bus ();

    alu_sequencer #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    // {ready, busy, done, err, Yin, Zin, Zlowout, Zhighout, Rin, LOin, HIin, ALU_ctrl}
    function automatic logic [15:0] obs();
        return {bus.req_ready, bus.busy, bus.done, bus.err, bus.Yin, bus.Zin,
                bus.Zlowout, bus.Zhighout, bus.Rin, bus.LOin, bus.HIin, bus.ALU_ctrl};
    endfunction

    function automatic int done_cycle(input int opv, input bit bz);
        int n;
        n = (opv == 2) ? MUL_N : (opv == 3) ? DIV_N : 1;
        if (opv > 11) return 1;
        if (opv == 3 && bz) return 3;
        if (opv == 2 || opv == 3) return 4 + n;
        return 3 + n;
    endfunction

    // Expected outputs in cycle c after the accept edge, from the documented latencies.
    function automatic logic [15:0] model(input int opv, input bit bz, input int c, input int prev_alu);
        bit legal, md, dbz, zlo, zhi;
        int n, dc, alu;
        legal = (opv <= 11);
        md    = (opv == 2) || (opv == 3);
        dbz   = (opv == 3) && bz;
        n     = (opv == 2) ? MUL_N : (opv == 3) ? DIV_N : 1;
        dc    = done_cycle(opv, bz);
        zlo   = legal && !dbz && (c == 2 + n);
        zhi   = md && !dbz && (c == 3 + n);
        alu   = (legal && c >= 2) ? opv : prev_alu;
        return {(c > dc), (c <= dc), (c == dc),
                (!legal || (dbz && c >= 3)),
                (legal && c == 1),
                (legal && !dbz && c == 1 + n),
                zlo, zhi, (zlo && !md), (zlo && md), zhi, 5'(alu)};
    endfunction

    // Steps from the accept edge through the IDLE cycle following DONE.
    task automatic check_trace(input int opv, input bit bz, input bit keep_valid,
                               input logic [4:0] op_after, input string name);
        int dc;
        logic [15:0] exp_v;
        dc = done_cycle(opv, bz);
        for (int c = 1; c <= dc + 1; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                bus.req_valid = keep_valid;
                bus.op        = op_after;
            end
            exp_v = model(opv, bz, c, last_alu);
            checks++;
            if (obs() !== exp_v) begin
                fails++;
                $display("FAIL %s op=%0d bz=%0d cycle %0d: got %b want %b", name, opv, bz, c, obs(), exp_v);
            end
        end
        if (opv <= 11) last_alu = opv;
    endtask

    task automatic wait_ready(input string name);
        int t;
        t = 0;
        while (bus.req_ready !== 1'b1 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t == 50) begin
            checks++;
            fails++;
            $display("FAIL %s ready timeout: got req_ready=%b want 1", name, bus.req_ready);
        end
    endtask

    task automatic run_op(input int opv, input bit bz, input string name);
        wait_ready(name);
        bus.op        = 5'(opv);
        bus.b_zero    = bz;
        bus.req_valid = 1'b1;
        check_trace(opv, bz, 1'b0, 5'(opv), name);
    endtask

    task automatic test_reset();
        clr = 1'b1;
        bus.req_valid = 1'b0;
        bus.op = 5'd0;
        bus.b_zero = 1'b0;
        #3;
        checks++;
        if (obs() !== 16'h0) begin
            fails++;
            $display("FAIL reset_state: got %b want %b", obs(), 16'h0);
        end
        @(negedge clk);
        clr = 1'b0;
        #1;
        checks++;
        if (obs() !== 16'h8000) begin
            fail_line("reset_release", obs(), 16'h8000);
        end
        last_alu = 0;
    endtask

    task automatic fail_line(input string name, input logic [15:0] got, input logic [15:0] want);
        fails++;
        $display("FAIL %s: got %b want %b", name, got, want);
    endtask

    task automatic test_add();
        run_op(0, 1'b0, "add");
    endtask

    task automatic test_mul();
        run_op(2, 1'b0, "mul");
    endtask

    task automatic test_div_zero();
        run_op(3, 1'b1, "div_zero");
        run_op(3, 1'b0, "div_after_err");
    endtask

    task automatic test_illegal();
        run_op(13, 1'b0, "illegal");
        run_op(9, 1'b1, "or_after_illegal");
    endtask

    task automatic test_random();
        int o;
        bit z;
        for (int i = 0; i < 24; i++) begin
            o = $urandom_range(0, 15);
            z = 1'($urandom_range(0, 1));
            run_op(o, z, "random");
        end
    endtask

    task automatic test_back_to_back();
        wait_ready("b2b");
        bus.op        = 5'd0;
        bus.b_zero    = 1'b0;
        bus.req_valid = 1'b1;
        check_trace(0, 1'b0, 1'b1, 5'd9, "b2b_first");
        check_trace(9, 1'b0, 1'b0, 5'd9, "b2b_second");
    endtask

    task automatic test_abort();
        run_op(14, 1'b0, "abort_pre_illegal");
        bus.op        = 5'd2;
        bus.b_zero    = 1'b0;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        clr = 1'b1;
        #1;
        checks++;
        if (obs() !== 16'h0) fail_line("abort_immediate", obs(), 16'h0);
        @(negedge clk);
        clr = 1'b0;
        #1;
        checks++;
        if (obs() !== 16'h8000) fail_line("abort_release", obs(), 16'h8000);
        last_alu = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs() !== 16'h8000) fail_line("abort_quiet", obs(), 16'h8000);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_div_zero();
        test_illegal();
        test_back_to_back();
        test_random();
        test_abort();
        run_op(1, 1'b0, "sub_after_abort");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that sequences one ALU operation at a time through the shared datapath. It accepts an opcode over a valid/ready handshake and walks the datapath through three steps: operand latch into Y, ALU compute with Z latch, and writeback. It drives the ALU's 5-bit op-select and all datapath register strobes, and stretches the compute phase for multiply and divide. It sits between the instruction-decode logic and the ALU/Z-register datapath.

## Interface
- MUL_CYCLES, 4, compute-phase length in cycles for multiply (1..255)
- DIV_CYCLES, 8, compute-phase length in cycles for divide (1..255)

- clk  in  1  system clock, rising-edge
- clr  in  1  reset, asynchronous, active-high
- req_valid  in  1  requester has an opcode on `op`
- req_ready  out  1  sequencer can accept; high only in IDLE and clr low
- op  in  5  ALU opcode: 0 add, 1 sub, 2 mul, 3 div, 4 shr, 5 shl, 6 ror, 7 rol, 8 and, 9 or, 10 neg, 11 not
- b_zero  in  1  datapath flag: B operand equals zero
- ALU_ctrl  out  5  op-select to the ALU
- Yin  out  1  latch bus operand into Y
- Zin  out  1  latch ALU ZHI/ZLO into the Z register
- Zlowout, Zhighout  out  1  drive Z low / Z high onto the bus
- Rin  out  1  write the bus into the destination register (non-mul/div result)
- LOin, HIin  out  1  write the bus into LO / HI (mul/div result)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error for the last operation (illegal op or divide by zero)

## Operation
- States: IDLE, LOAD_Y, EXEC, WAIT, WB_LO, WB_HI, DONE.
- IDLE: a transfer occurs on a rising edge where req_valid && req_ready. On transfer, op is captured into op_q and err clears.
  - op > 11: go to DONE with err=1; no strobes.
  - Otherwise: go to LOAD_Y.
- LOAD_Y: Yin=1 for one cycle, then EXEC.
- EXEC / WAIT: ALU_ctrl=op_q. The compute phase lasts N cycles: N=MUL_CYCLES for op 2, DIV_CYCLES for op 3, 1 otherwise. The phase is EXEC followed by N-1 WAIT cycles, counted by an 8-bit down-counter. Zin=1 only in the final compute cycle.
- Divide by zero: for op 3, b_zero is sampled in EXEC. If set, err=1, no Zin, no writeback, and the next state is DONE.
- WB_LO: Zlowout=1. Also LOin=1 for mul/div; otherwise Rin=1.
  - Next state is WB_HI for mul/div, otherwise DONE.
- WB_HI: Zhighout=1 and HIin=1, then DONE.
- DONE: done=1 for one cycle, then IDLE. err holds until the next accepted request.
- ALU_ctrl is a registered copy of op_q and holds its value from EXEC until the next accept.
- At most one strobe among Yin/Zin/Zlowout/Zhighout is high in any cycle.

## Timing
- Reset (clr high, asynchronous): state=IDLE, counter=0, op_q=0, ALU_ctrl=0, err=0. All strobes, busy and done are 0. req_ready=0 while clr is high.
- All outputs except req_ready are registered Moore decodes; there is no combinational path from input to output.
- Latency is counted from the accept edge (cycle 0):
  - Simple op: LOAD_Y in cycle 1, EXEC in 2, WB_LO in 3, done in cycle 3+N = 4.
  - Mul/div: WB_LO in cycle 2+N, WB_HI in 3+N, done in 4+N.
  - Div-by-zero: done in cycle 3.
  - Illegal op: done in cycle 1.
- Back-to-back requests: req_ready is low in DONE. The earliest next accept is the edge ending the first IDLE cycle after DONE, so throughput is one op per 5 cycles minimum.
- req_valid while busy is ignored; no queuing. The requester holds op stable until the transfer.
- clr asserted mid-operation aborts immediately: strobes drop asynchronously, no done pulse, and err clears.

## Test plan
- Reset: assert clr in the middle of a WAIT of a mul, then release. Required: all strobes 0 immediately, busy=0, no done pulse, req_ready=1 on the first cycle after release.
- Add (op=0): accept at cycle 0. Required: Yin@1; ALU_ctrl=0 and Zin@2; Zlowout+Rin@3; done@4; err=0; HIin/LOin never asserted.
- Multiply with MUL_CYCLES=4 (op=2): Required: Zin only @5; Zlowout+LOin@6; Zhighout+HIin@7; done@8; ALU_ctrl=2 held from 2 through 7.
- Divide by zero (op=3, b_zero=1, DIV_CYCLES=8): Required: Yin@1, done@3, err=1. Zin, LOin and HIin never asserted. err clears on the next accept.
- Illegal op=13: Required: done@1, err=1, no strobes.
- Handshake: hold req_valid=1 continuously with ops 0 then 9. Required: the second accept occurs only after DONE plus one IDLE cycle; req_valid during busy has no effect; the second op completes with ALU_ctrl=9.
